// File: rtl/gsim_mtx_fetch.sv
// Read scheduler between the GSIM matrix memory and the Gauss-Seidel datapath.
// Walks b then A rows for each matrix, credit-limits reads and buffers tagged returns.
module gsim_mtx_fetch #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LINES = 17
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic [4:0]   i_matrix_num,
  output logic         o_mem_rreq,
  output logic [9:0]   o_mem_addr,
  input  logic         i_mem_rrdy,
  input  logic [255:0] i_mem_dout,
  input  logic         i_mem_dout_vld,
  output logic         o_row_vld,
  output logic [255:0] o_row_data,
  output logic [4:0]   o_row_idx,
  output logic [4:0]   o_row_mtx,
  output logic         o_row_last,
  input  logic         i_row_rdy,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_err
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned TW = 11;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [4:0]    num_q, num_d;
  logic [4:0]    row_cnt_q, row_cnt_d;
  logic [4:0]    mtx_cnt_q, mtx_cnt_d;
  logic          all_raised_q, all_raised_d;
  logic          last_popped_q, last_popped_d;
  logic          rreq_q, rreq_d;
  logic [9:0]    addr_q, addr_d;
  logic [TW-1:0] req_tag_q, req_tag_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic [TW-1:0]  tq_mem [DEPTH];
  logic [PW-1:0]  tq_wr_q, tq_rd_q;
  logic [255:0]   dmem [DEPTH];
  logic [TW-1:0]  fmem [DEPTH];
  logic [PW-1:0]  f_wr_q, f_rd_q;

  logic          accept, ret, pop, can_raise;
  logic [4:0]    line_idx;
  logic [9:0]    line_addr;
  logic          line_last;
  logic [TW-1:0] head_tag;

  assign accept   = rreq_q & i_mem_rrdy;
  assign ret      = i_mem_dout_vld & (out_q != '0);
  assign pop      = (cnt_q != '0) & i_row_rdy;
  assign head_tag = fmem[f_rd_q];

  // The registered request counts as a credit until it moves into out_q.
  assign can_raise = (state_q == ISSUE) && !all_raised_q && (!rreq_q || accept) &&
                     ((int'(out_q) + int'(cnt_q) + int'(rreq_q)) < int'(DEPTH));

  assign line_idx  = (row_cnt_q == 5'd0) ? 5'd16 : row_cnt_q - 5'd1;
  assign line_addr = ({5'b0, mtx_cnt_q} * 10'(LINES)) +
                     ((row_cnt_q == 5'd0) ? 10'd16 : 10'd16 - {5'b0, row_cnt_q});
  assign line_last = (mtx_cnt_q == num_q - 5'd1) && (row_cnt_q == 5'(LINES - 1));

  always_comb begin
    state_d       = state_q;
    num_d         = num_q;
    row_cnt_d     = row_cnt_q;
    mtx_cnt_d     = mtx_cnt_q;
    all_raised_d  = all_raised_q;
    last_popped_d = last_popped_q;
    rreq_d        = rreq_q;
    addr_d        = addr_q;
    req_tag_d     = req_tag_q;
    out_d         = out_q + CW'(accept) - CW'(ret);
    cnt_d         = cnt_q + CW'(ret) - CW'(pop);
    err_d         = err_q | (i_mem_dout_vld & (out_q == '0));

    if (can_raise) begin
      rreq_d    = 1'b1;
      addr_d    = line_addr;
      req_tag_d = {line_idx, mtx_cnt_q, line_last};
      if (line_last) begin
        all_raised_d = 1'b1;
      end else if (row_cnt_q == 5'(LINES - 1)) begin
        row_cnt_d = 5'd0;
        mtx_cnt_d = mtx_cnt_q + 5'd1;
      end else begin
        row_cnt_d = row_cnt_q + 5'd1;
      end
    end else if (accept) begin
      rreq_d = 1'b0;
    end

    if (pop && head_tag[0]) begin
      last_popped_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (i_start) begin
          num_d         = i_matrix_num;
          row_cnt_d     = 5'd0;
          mtx_cnt_d     = 5'd0;
          all_raised_d  = 1'b0;
          last_popped_d = 1'b0;
          state_d       = (i_matrix_num == 5'd0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (accept && req_tag_q[0]) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((out_q == '0) && (cnt_q == '0) && last_popped_q) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q       <= IDLE;
      num_q         <= '0;
      row_cnt_q     <= '0;
      mtx_cnt_q     <= '0;
      all_raised_q  <= 1'b0;
      last_popped_q <= 1'b0;
      rreq_q        <= 1'b0;
      addr_q        <= '0;
      req_tag_q     <= '0;
      out_q         <= '0;
      cnt_q         <= '0;
      err_q         <= 1'b0;
      tq_wr_q       <= '0;
      tq_rd_q       <= '0;
      f_wr_q        <= '0;
      f_rd_q        <= '0;
    end else begin
      state_q       <= state_d;
      num_q         <= num_d;
      row_cnt_q     <= row_cnt_d;
      mtx_cnt_q     <= mtx_cnt_d;
      all_raised_q  <= all_raised_d;
      last_popped_q <= last_popped_d;
      rreq_q        <= rreq_d;
      addr_q        <= addr_d;
      req_tag_q     <= req_tag_d;
      out_q         <= out_d;
      cnt_q         <= cnt_d;
      err_q         <= err_d;
      if (accept) tq_wr_q <= tq_wr_q + PW'(1);
      if (ret) begin
        tq_rd_q <= tq_rd_q + PW'(1);
        f_wr_q  <= f_wr_q + PW'(1);
      end
      if (pop) f_rd_q <= f_rd_q + PW'(1);
    end
  end

  // Storage arrays need no reset; every read is gated by a valid count.
  always_ff @(posedge i_clk) begin
    if (accept) tq_mem[tq_wr_q] <= req_tag_q;
    if (ret) begin
      dmem[f_wr_q] <= i_mem_dout;
      fmem[f_wr_q] <= tq_mem[tq_rd_q];
    end
  end

  always_comb begin
    o_row_vld  = (cnt_q != '0);
    o_row_data = '0;
    o_row_idx  = '0;
    o_row_mtx  = '0;
    o_row_last = 1'b0;
    if (o_row_vld) begin
      o_row_data = dmem[f_rd_q];
      {o_row_idx, o_row_mtx, o_row_last} = head_tag;
    end
  end

  assign o_mem_rreq = rreq_q;
  assign o_mem_addr = addr_q;
  assign o_busy     = (state_q != IDLE);
  assign o_done     = (state_q == DONE);
  assign o_err      = err_q;

endmodule
